// File: rtl/clken_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clken_pkg
// Description : Shared constants, lock-state encoding and init-vector helper
//               for the clock-enable NCO.
// Revision    : 1.0 - initial release
// ============================================================================
package clken_pkg;

    localparam logic CFG_FIELD_INC = 1'b0;
    localparam logic CFG_FIELD_PH  = 1'b1;

    localparam int MAX_CH = 16;
    localparam int MAX_W  = 32;

    typedef enum logic [0:0] {
        ST_SETTLE = 1'b0,
        ST_RUN    = 1'b1
    } lock_state_t;

    // Pull channel idx (w bits wide) out of a packed per-channel init vector.
    function automatic logic [MAX_W-1:0] init_slice(
        input logic [MAX_CH*MAX_W-1:0] vec,
        input int                      idx,
        input int                      w
    );
        logic [MAX_CH*MAX_W-1:0] v_shift;
        logic [MAX_W-1:0]        v_res;
        v_shift = vec >> (idx * w);
        for (int b = 0; b < MAX_W; b++) begin
            v_res[b] = (b < w) ? v_shift[b] : 1'b0;
        end
        return v_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clken_channel.sv
`default_nettype none
// ============================================================================
// Module      : clken_channel
// Description : One phase accumulator with carry-out enable and MSB square wave.
// Revision    : 1.0 - initial release
// ============================================================================
module clken_channel
    import clken_pkg::*;
#(
    parameter int               ACC_W     = 32,
    parameter logic [ACC_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run,
    input  logic             i_load,
    input  logic [ACC_W-1:0] i_load_val,
    input  logic [ACC_W-1:0] i_inc,
    output logic             o_ce,
    output logic             o_sq
);

    logic [ACC_W-1:0] r_acc;
    logic             r_ce;
    logic             r_sq;
    logic [ACC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, i_inc};

    // Outputs register the same sum that updates the accumulator, so a
    // wrap shows up on ce in the same cycle the accumulator wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= RESET_VAL;
            r_ce  <= 1'b0;
            r_sq  <= 1'b0;
        end else if (i_load) begin
            r_acc <= i_load_val;
            r_ce  <= 1'b0;
            r_sq  <= 1'b0;
        end else if (i_run) begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ce  <= w_sum[ACC_W];
            r_sq  <= w_sum[ACC_W-1];
        end else begin
            r_ce  <= 1'b0;
            r_sq  <= 1'b0;
        end
    end

    assign o_ce = r_ce;
    assign o_sq = r_sq;

endmodule
`default_nettype wire

// File: rtl/clken_nco.sv
`default_nettype none
// ============================================================================
// Module      : clken_nco
// Description : Multi-channel clock-enable generator: shadow/active config,
//               shared lock counter and one NCO channel per output.
// Revision    : 1.0 - initial release
// ============================================================================
module clken_nco
    import clken_pkg::*;
#(
    parameter int                        CHANNELS    = 2,
    parameter int                        ACC_W       = 32,
    parameter int                        LOCK_CYCLES = 16,
    parameter logic [CHANNELS*ACC_W-1:0] INC_INIT    = {CHANNELS{{2'b01, {(ACC_W-2){1'b0}}}}},
    parameter logic [CHANNELS*ACC_W-1:0] PHASE_INIT  = '0
) (
    input  logic                                clkin,
    input  logic                                rst,
    input  logic                                cfg_we,
    input  logic [($clog2(CHANNELS) | 1)-1:0]   cfg_sel,
    input  logic                                cfg_field,
    input  logic [ACC_W-1:0]                    cfg_data,
    input  logic                                cfg_commit,
    output logic [CHANNELS-1:0]                 ce,
    output logic [CHANNELS-1:0]                 sq,
    output logic                                locked
);

    localparam int                CNT_W      = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(LOCK_CYCLES - 1);

    localparam logic [MAX_CH*MAX_W-1:0] c_inc_ext = (MAX_CH*MAX_W)'(INC_INIT);
    localparam logic [MAX_CH*MAX_W-1:0] c_ph_ext  = (MAX_CH*MAX_W)'(PHASE_INIT);

    lock_state_t      r_state;
    lock_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_lock_cnt;
    logic [CNT_W-1:0] w_lock_cnt_nxt;

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state    <= ST_SETTLE;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    // A commit always restarts settling, even when already settling.
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        if (cfg_commit) begin
            w_state_nxt    = ST_SETTLE;
            w_lock_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (r_lock_cnt == c_cnt_last) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
                    end
                end
                ST_RUN:  w_state_nxt = ST_RUN;
                default: w_state_nxt = ST_SETTLE;
            endcase
        end
    end

    assign locked = (r_state == ST_RUN);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [ACC_W-1:0] c_inc_init = ACC_W'(init_slice(c_inc_ext, i, ACC_W));
        localparam logic [ACC_W-1:0] c_ph_init  = ACC_W'(init_slice(c_ph_ext, i, ACC_W));

        logic [ACC_W-1:0] r_shadow_inc;
        logic [ACC_W-1:0] r_shadow_ph;
        logic [ACC_W-1:0] r_active_inc;
        logic             w_hit;

        assign w_hit = cfg_we && (32'(cfg_sel) == i);

        // Commit reads the shadows before this edge's write lands.
        always_ff @(posedge clkin) begin
            if (rst) begin
                r_shadow_inc <= c_inc_init;
                r_shadow_ph  <= c_ph_init;
                r_active_inc <= c_inc_init;
            end else begin
                if (cfg_commit) begin
                    r_active_inc <= r_shadow_inc;
                end
                if (w_hit && (cfg_field == CFG_FIELD_INC)) begin
                    r_shadow_inc <= cfg_data;
                end
                if (w_hit && (cfg_field == CFG_FIELD_PH)) begin
                    r_shadow_ph <= cfg_data;
                end
            end
        end

        clken_channel #(
            .ACC_W     (ACC_W),
            .RESET_VAL (c_ph_init)
        ) u_channel (
            .clk        (clkin),
            .rst        (rst),
            .i_run      (locked),
            .i_load     (cfg_commit),
            .i_load_val (r_shadow_ph),
            .i_inc      (r_active_inc),
            .o_ce       (ce[i]),
            .o_sq       (sq[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clken_nco.sv
`default_nettype none
// ============================================================================
// Module      : tb_clken_nco
// Description : Self-checking bench for clken_nco against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clken_nco;

    localparam int CH   = 3;
    localparam int LOCK = 16;

    logic        clkin = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_sel;
    logic        cfg_field;
    logic [31:0] cfg_data;
    logic        cfg_commit;
    logic [2:0]  ce;
    logic [2:0]  sq;
    logic        locked;

    int checks = 0;
    int errors = 0;

    // Model: active/shadow settings and edges since the last reset or commit.
    logic [31:0] m_inc    [CH];
    logic [31:0] m_ph     [CH];
    logic [31:0] m_sh_inc [CH];
    logic [31:0] m_sh_ph  [CH];
    int          m_k;

    always #5 clkin = ~clkin;

    clken_nco #(
        .CHANNELS    (CH),
        .ACC_W       (32),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .clkin      (clkin),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_field  (cfg_field),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .ce         (ce),
        .sq         (sq),
        .locked     (locked)
    );

    // After n adds the phase is ph + n*inc; a pulse marks a change in the
    // number of whole turns completed.
    function automatic logic [6:0] exp_out();
        logic [63:0] a1;
        logic [63:0] a0;
        logic [2:0]  e_ce;
        logic [2:0]  e_sq;
        longint      n;
        e_ce = '0;
        e_sq = '0;
        n    = longint'(m_k) - LOCK;
        if (n >= 1) begin
            for (int c = 0; c < CH; c++) begin
                a1 = {32'b0, m_ph[c]} + 64'(n) * {32'b0, m_inc[c]};
                a0 = {32'b0, m_ph[c]} + 64'(n - 1) * {32'b0, m_inc[c]};
                e_ce[c] = (a1[63:32] != a0[63:32]);
                e_sq[c] = a1[31];
            end
        end
        return {(m_k >= LOCK), e_ce, e_sq};
    endfunction

    task automatic idle();
        rst        = 1'b0;
        cfg_we     = 1'b0;
        cfg_sel    = '0;
        cfg_field  = 1'b0;
        cfg_data   = '0;
        cfg_commit = 1'b0;
    endtask

    task automatic tick();
        @(posedge clkin);
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                m_inc[c] = 32'h4000_0000; m_sh_inc[c] = 32'h4000_0000;
                m_ph[c]  = 32'h0;         m_sh_ph[c]  = 32'h0;
            end
            m_k = 0;
        end else begin
            if (cfg_commit) begin
                for (int c = 0; c < CH; c++) begin
                    m_inc[c] = m_sh_inc[c];
                    m_ph[c]  = m_sh_ph[c];
                end
                m_k = 0;
            end else begin
                m_k++;
            end
            if (cfg_we && int'(cfg_sel) < CH) begin
                if (cfg_field) m_sh_ph[cfg_sel]  = cfg_data;
                else           m_sh_inc[cfg_sel] = cfg_data;
            end
        end
        #1;
    endtask

    task automatic cfg_write(input int sel, input logic field, input logic [31:0] data);
        cfg_we = 1'b1; cfg_sel = 3'(sel); cfg_field = field; cfg_data = data;
        tick();
        idle();
    endtask

    task automatic do_commit();
        cfg_commit = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        int first_lock;
        int first_ce0;
        rst = 1'b1;
        tick(); tick();
        idle();
        checks++;
        if ({locked, ce, sq} !== 7'b0)
            begin errors++; $display("FAIL reset_state got %b expected 0000000", {locked, ce, sq}); end
        first_lock = -1; first_ce0 = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            checks++;
            if ({locked, ce, sq} !== exp_out())
                begin errors++; $display("FAIL reset_run c=%0d got %b expected %b", c, {locked, ce, sq}, exp_out()); end
            if (locked === 1'b1 && first_lock < 0) first_lock = c;
            if (ce[0] === 1'b1 && first_ce0 < 0) first_ce0 = c;
        end
        checks++;
        if (first_lock != 16)
            begin errors++; $display("FAIL lock_edge got %0d expected 16", first_lock); end
        checks++;
        if (first_ce0 != 20)
            begin errors++; $display("FAIL first_ce0 got %0d expected 20", first_ce0); end
    endtask

    task automatic test_commit_inc();
        int first_ce0;
        int first_ce1;
        cfg_write(1, 1'b0, 32'h8000_0000);
        do_commit();
        first_ce0 = -1; first_ce1 = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            checks++;
            if ({locked, ce, sq} !== exp_out())
                begin errors++; $display("FAIL commit_inc c=%0d got %b expected %b", c, {locked, ce, sq}, exp_out()); end
            if (ce[0] === 1'b1 && first_ce0 < 0) first_ce0 = c;
            if (ce[1] === 1'b1 && first_ce1 < 0) first_ce1 = c;
        end
        checks++;
        if (first_ce1 != 18 || first_ce0 != 20)
            begin errors++; $display("FAIL commit_first_pulses got ce1=%0d ce0=%0d expected 18 20", first_ce1, first_ce0); end
    endtask

    task automatic test_phase();
        int first_ce0;
        int first_ce1;
        cfg_write(0, 1'b0, 32'h4000_0000);
        cfg_write(1, 1'b0, 32'h4000_0000);
        cfg_write(1, 1'b1, 32'hC000_0000);
        do_commit();
        first_ce0 = -1; first_ce1 = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            checks++;
            if ({locked, ce, sq} !== exp_out())
                begin errors++; $display("FAIL phase c=%0d got %b expected %b", c, {locked, ce, sq}, exp_out()); end
            if (ce[0] === 1'b1 && first_ce0 < 0) first_ce0 = c;
            if (ce[1] === 1'b1 && first_ce1 < 0) first_ce1 = c;
        end
        checks++;
        if (first_ce1 < 0 || first_ce0 - first_ce1 != 3)
            begin errors++; $display("FAIL phase_lead got ce1=%0d ce0=%0d expected lead 3", first_ce1, first_ce0); end
    endtask

    task automatic test_fractional();
        int   pulses, last, bad_gap, sq1_changes, ce1_count;
        logic sq1_ref;
        cfg_write(0, 1'b0, 32'h5555_5555);
        cfg_write(1, 1'b0, 32'h0);
        cfg_write(1, 1'b1, $urandom);
        cfg_write(2, 1'b0, $urandom);
        do_commit();
        pulses = 0; last = -1; bad_gap = 0; sq1_changes = 0; ce1_count = 0; sq1_ref = 1'b0;
        for (int c = 1; c <= LOCK + 3000; c++) begin
            tick();
            checks++;
            if ({locked, ce, sq} !== exp_out())
                begin errors++; $display("FAIL fractional c=%0d got %b expected %b", c, {locked, ce, sq}, exp_out()); end
            if (c > LOCK) begin
                if (ce[0] === 1'b1) begin
                    if (last >= 0 && (c - last) != 3 && (c - last) != 4) bad_gap++;
                    last = c;
                    pulses++;
                end
                if (ce[1] === 1'b1) ce1_count++;
                if (c == LOCK + 1) sq1_ref = sq[1];
                else if (sq[1] !== sq1_ref) sq1_changes++;
            end
        end
        checks++;
        if (pulses != 999 && pulses != 1000)
            begin errors++; $display("FAIL frac_pulses got %0d expected 999 or 1000", pulses); end
        checks++;
        if (bad_gap != 0)
            begin errors++; $display("FAIL frac_spacing got %0d bad gaps expected 0", bad_gap); end
        checks++;
        if (ce1_count != 0 || sq1_changes != 0)
            begin errors++; $display("FAIL zero_inc got ce=%0d sq_changes=%0d expected 0 0", ce1_count, sq1_changes); end
    endtask

    task automatic test_we_commit();
        logic [31:0] v;
        v = $urandom_range(32'h0100_0000, 32'hF000_0000);
        cfg_we = 1'b1; cfg_sel = 3'd0; cfg_field = 1'b0; cfg_data = v; cfg_commit = 1'b1;
        tick();
        idle();
        for (int c = 1; c <= 30; c++) begin
            tick();
            checks++;
            if ({locked, ce, sq} !== exp_out())
                begin errors++; $display("FAIL we_commit_same c=%0d got %b expected %b", c, {locked, ce, sq}, exp_out()); end
        end
        do_commit();
        for (int c = 1; c <= 30; c++) begin
            tick();
            checks++;
            if ({locked, ce, sq} !== exp_out())
                begin errors++; $display("FAIL we_commit_second c=%0d got %b expected %b", c, {locked, ce, sq}, exp_out()); end
        end
        cfg_write(CH, 1'b0, 32'h0);
        cfg_write(CH, 1'b1, $urandom);
        do_commit();
        for (int c = 1; c <= 30; c++) begin
            tick();
            checks++;
            if ({locked, ce, sq} !== exp_out())
                begin errors++; $display("FAIL bad_sel c=%0d got %b expected %b", c, {locked, ce, sq}, exp_out()); end
        end
    endtask

    task automatic test_commit_settle();
        int first_lock;
        do_commit();
        repeat (9) tick();
        do_commit();
        first_lock = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            checks++;
            if ({locked, ce, sq} !== exp_out())
                begin errors++; $display("FAIL settle_commit c=%0d got %b expected %b", c, {locked, ce, sq}, exp_out()); end
            if (locked === 1'b1 && first_lock < 0) first_lock = c;
        end
        checks++;
        if (first_lock != 16)
            begin errors++; $display("FAIL settle_relock got %0d expected 16", first_lock); end
        cfg_write(2, 1'b0, 32'h1234_5678);
        rst = 1'b1;
        tick();
        idle();
        checks++;
        if ({locked, ce, sq} !== 7'b0)
            begin errors++; $display("FAIL midrun_reset got %b expected 0000000", {locked, ce, sq}); end
        for (int c = 1; c <= 30; c++) begin
            tick();
            checks++;
            if ({locked, ce, sq} !== exp_out())
                begin errors++; $display("FAIL after_reset c=%0d got %b expected %b", c, {locked, ce, sq}, exp_out()); end
        end
    endtask

    task automatic test_random();
        int r;
        for (int c = 1; c <= 1500; c++) begin
            r = int'($urandom_range(0, 199));
            idle();
            if (r < 40) begin
                cfg_we    = 1'b1;
                cfg_sel   = 3'($urandom_range(0, CH));
                cfg_field = 1'($urandom_range(0, 1));
                cfg_data  = (r < 20) ? ($urandom >> $urandom_range(0, 4)) : $urandom;
            end
            if (r >= 40 && r < 46) cfg_commit = 1'b1;
            if (r == 199) rst = 1'b1;
            tick();
            checks++;
            if ({locked, ce, sq} !== exp_out())
                begin errors++; $display("FAIL random c=%0d got %b expected %b", c, {locked, ce, sq}, exp_out()); end
        end
        idle();
    endtask

    initial begin
        idle();
        m_k = 0;
        test_reset();
        test_commit_inc();
        test_phase();
        test_fractional();
        test_we_commit();
        test_commit_settle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
